// File: rtl/pc_sequencer_if.sv
// Instruction-fetch handshake bundle between pc_sequencer (master) and
// instruction memory (slave).
interface pc_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             fetch_valid;
  logic             fetch_ready;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus1;

  modport master (
    output fetch_valid,
    output pc,
    output pc_plus1,
    input  fetch_ready
  );

  modport slave (
    input  fetch_valid,
    input  pc,
    input  pc_plus1,
    output fetch_ready
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter owner and next-PC sequencer for the single-cycle core.
// Optional PC_SEQ_PERF_EN adds saturating retired/taken counters.
module pc_sequencer #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] TRAP_PC  = WIDTH'(32'h0000_0010)
) (
  input  logic             clk,
  input  logic             reset,
  pc_sequencer_if.master   fetch,
  input  logic             branch,
  input  logic             zero,
  input  logic [WIDTH-1:0] sign_imm,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             halt,
  input  logic             trap_req,
  output logic             trap_ack,
  output logic [1:0]       state
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [31:0]      retired_cnt,
  output logic [31:0]      taken_cnt
`endif
);

  typedef enum logic [1:0] {
    BOOT   = 2'b00,
    RUN    = 2'b01,
    STALL  = 2'b10,
    HALTED = 2'b11
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] pc_q;
  logic             fetch_valid_q;
  logic             trap_pend_q;

  logic [WIDTH-1:0] pc_plus1;
  logic [WIDTH-1:0] branch_target;
  logic [WIDTH-1:0] next_pc;
  logic             handshake;
  logic             trap_take;
  logic             redirect;

  assign pc_plus1          = pc_q + WIDTH'(1);
  assign branch_target     = sign_imm + pc_plus1;
  assign fetch.pc          = pc_q;
  assign fetch.pc_plus1    = pc_plus1;
  assign fetch.fetch_valid = fetch_valid_q;
  assign state             = state_q;

  // fetch_valid_q is high only in RUN/STALL, so the handshake itself
  // excludes BOOT and HALTED.
  assign handshake = fetch_valid_q & fetch.fetch_ready;
  assign trap_take = handshake & (trap_req | trap_pend_q);
  assign redirect  = trap_take | (handshake & (jump | (branch & zero)));

  // trap_ack must land in the handshake cycle itself: the requester drops
  // trap_req on seeing it, so a registered ack would re-trigger the trap.
  assign trap_ack = trap_take;

  always_comb begin
    next_pc = pc_plus1;
    if (trap_req | trap_pend_q)
      next_pc = TRAP_PC;
    else if (halt)
      next_pc = pc_q;
    else if (jump)
      next_pc = jump_target;
    else if (branch & zero)
      next_pc = branch_target;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      state_q       <= BOOT;
      fetch_valid_q <= 1'b0;
      trap_pend_q   <= 1'b0;
    end else begin
      unique case (state_q)
        BOOT: begin
          state_q       <= RUN;
          fetch_valid_q <= 1'b1;
        end
        RUN, STALL: begin
          if (handshake) begin
            pc_q        <= next_pc;
            trap_pend_q <= 1'b0;
            if (!trap_take && halt) begin
              state_q       <= HALTED;
              fetch_valid_q <= 1'b0;
            end else begin
              state_q <= RUN;
            end
          end else begin
            state_q <= STALL;
            if (trap_req)
              trap_pend_q <= 1'b1;
          end
        end
        HALTED: begin
          state_q       <= HALTED;
          fetch_valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_cnt <= '0;
      taken_cnt   <= '0;
    end else begin
      if (handshake && retired_cnt != '1)
        retired_cnt <= retired_cnt + 32'd1;
      if (redirect && taken_cnt != '1)
        taken_cnt <= taken_cnt + 32'd1;
    end
  end
`else
  logic unused_redirect;
  assign unused_redirect = redirect;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a driver issues directed cycles and
// queues hand-computed expectations; a monitor pops and compares them.
module tb_pc_sequencer;

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;
  localparam logic [31:0] M3     = 32'hFFFF_FFFD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] sign_imm = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        halt = 1'b0;
  logic        trap_req = 1'b0;
  logic        trap_ack;
  logic [1:0]  state;
`ifdef PC_SEQ_PERF_EN
  logic [31:0] retired_cnt;
  logic [31:0] taken_cnt;
`endif

  pc_sequencer_if #(.WIDTH(32)) fetch_bus ();

  pc_sequencer #(
    .WIDTH   (32),
    .RESET_PC(32'h0000_0000),
    .TRAP_PC (32'h0000_0010)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch      (fetch_bus.master),
    .branch     (branch),
    .zero       (zero),
    .sign_imm   (sign_imm),
    .jump       (jump),
    .jump_target(jump_target),
    .halt       (halt),
    .trap_req   (trap_req),
    .trap_ack   (trap_ack),
    .state      (state)
`ifdef PC_SEQ_PERF_EN
    ,
    .retired_cnt(retired_cnt),
    .taken_cnt  (taken_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned id;
    logic [31:0] pc;
    logic [1:0]  st;
    logic        fv;
    logic        ack;
    logic        perf;
    logic [31:0] ret;
    logic [31:0] tkn;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc_id   = 0;
  logic        perf_pend = 1'b0;
  logic [31:0] perf_ret  = '0;
  logic [31:0] perf_tkn  = '0;

  task automatic check(input string name, input int unsigned id,
                       input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  task automatic expect_perf(input logic [31:0] ret, input logic [31:0] tkn);
    perf_pend = 1'b1;
    perf_ret  = ret;
    perf_tkn  = tkn;
  endtask

  // Drive one cycle's inputs just after the edge and queue the outputs the
  // DUT should present during that cycle.
  task automatic cyc(input logic rst, input logic rdy, input logic br,
                     input logic z, input logic [31:0] imm, input logic j,
                     input logic [31:0] jt, input logic h, input logic tr,
                     input logic chk, input logic [31:0] epc,
                     input logic [1:0] est, input logic efv, input logic eack);
    exp_t e;
    #1;
    reset = rst;  fetch_bus.fetch_ready = rdy;
    branch = br;  zero = z;  sign_imm = imm;
    jump = j;     jump_target = jt;
    halt = h;     trap_req = tr;
    if (chk) begin
      e.id = cyc_id;  e.pc = epc;  e.st = est;  e.fv = efv;  e.ack = eack;
      e.perf = perf_pend;  e.ret = perf_ret;  e.tkn = perf_tkn;
      sb.push_back(e);
    end
    perf_pend = 1'b0;
    cyc_id++;
    @(posedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pc",          e.id, fetch_bus.pc, e.pc);
        check("pc_plus1",    e.id, fetch_bus.pc_plus1, e.pc + 32'd1);
        check("state",       e.id, {30'd0, state}, {30'd0, e.st});
        check("fetch_valid", e.id, {31'd0, fetch_bus.fetch_valid}, {31'd0, e.fv});
        check("trap_ack",    e.id, {31'd0, trap_ack}, {31'd0, e.ack});
`ifdef PC_SEQ_PERF_EN
        if (e.perf) begin
          check("retired_cnt", e.id, retired_cnt, e.ret);
          check("taken_cnt",   e.id, taken_cnt, e.tkn);
        end
`endif
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int unsigned wait_cycles;
    fetch_bus.fetch_ready = 1'b0;
    @(posedge clk);
    // reset, then straight-line fetch 0..4
    cyc(1,0,0,0,'0,0,'0,0,0, 0, 32'd0, S_BOOT, 0,0);
    cyc(1,0,0,0,'0,0,'0,0,0, 1, 32'd0, S_BOOT, 0,0);
    cyc(0,1,0,0,'0,0,'0,0,0, 1, 32'd0, S_BOOT, 0,0);
    for (int i = 0; i < 4; i++)
      cyc(0,1,0,0,'0,0,'0,0,0, 1, 32'(i), S_RUN, 1,0);
    expect_perf(32'd4, 32'd0);
    cyc(0,1,0,0,'0,1,32'd8,0,0, 1, 32'd4, S_RUN, 1,0);
    // taken branch 8 + 1 - 3 = 6, then not-taken from 8 -> 9
    cyc(0,1,1,1,M3,0,'0,0,0, 1, 32'd8, S_RUN, 1,0);
    cyc(0,1,0,0,'0,1,32'd8,0,0, 1, 32'd6, S_RUN, 1,0);
    cyc(0,1,1,0,M3,0,'0,0,0, 1, 32'd8, S_RUN, 1,0);
    cyc(0,1,0,0,'0,1,32'd5,0,0, 1, 32'd9, S_RUN, 1,0);
    // stall three cycles at 5 with a jump presented, then release
    cyc(0,0,0,0,'0,1,32'd40,0,0, 1, 32'd5, S_RUN, 1,0);
    cyc(0,0,0,0,'0,1,32'd40,0,0, 1, 32'd5, S_STALL, 1,0);
    cyc(0,0,0,0,'0,1,32'd40,0,0, 1, 32'd5, S_STALL, 1,0);
    cyc(0,1,0,0,'0,1,32'd40,0,0, 1, 32'd5, S_STALL, 1,0);
    cyc(0,1,0,0,'0,1,32'd7,0,0, 1, 32'd40, S_RUN, 1,0);
    // stalled at 7, one-cycle trap pulse, release with jump -> trap wins
    cyc(0,0,0,0,'0,0,'0,0,0, 1, 32'd7, S_RUN, 1,0);
    cyc(0,0,0,0,'0,0,'0,0,1, 1, 32'd7, S_STALL, 1,0);
    cyc(0,1,0,0,'0,1,32'd99,0,0, 1, 32'd7, S_STALL, 1,1);
    expect_perf(32'd12, 32'd7);
    cyc(0,1,0,0,'0,1,32'd12,0,0, 1, 32'd16, S_RUN, 1,0);
    // halt at 12, then ten cycles of ignored trap/jump
    cyc(0,1,0,0,'0,0,'0,1,0, 1, 32'd12, S_RUN, 1,0);
    for (int i = 0; i < 10; i++)
      cyc(0,1,0,0,'0,1,32'd3,0,1, 1, 32'd12, S_HALT, 0,0);
    cyc(1,1,0,0,'0,0,'0,0,0, 1, 32'd12, S_HALT, 0,0);
    cyc(0,1,0,0,'0,0,'0,0,0, 1, 32'd0, S_BOOT, 0,0);
    // wrap-around from all-ones
    cyc(0,1,0,0,'0,1,32'hFFFF_FFFF,0,0, 1, 32'd0, S_RUN, 1,0);
    cyc(0,1,0,0,'0,0,'0,0,0, 1, 32'hFFFF_FFFF, S_RUN, 1,0);
    // trap beats halt on the same handshake
    cyc(0,1,0,0,'0,0,'0,1,1, 1, 32'd0, S_RUN, 1,1);
    // reset while stalled
    cyc(0,0,0,0,'0,0,'0,0,0, 1, 32'd16, S_RUN, 1,0);
    cyc(1,0,0,0,'0,0,'0,0,0, 1, 32'd16, S_STALL, 1,0);
    expect_perf(32'd0, 32'd0);
    cyc(0,1,0,0,'0,0,'0,0,0, 1, 32'd0, S_BOOT, 0,0);
    cyc(0,1,0,0,'0,0,'0,0,0, 1, 32'd0, S_RUN, 1,0);
    cyc(0,1,0,0,'0,0,'0,0,0, 1, 32'd1, S_RUN, 1,0);

    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (sb.size() > 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter register and sequences next-PC selection for the single-cycle core.
- Drives the branch-target adder: target = SignImm + PCPlus1.
- Chooses among sequential, branch, jump and trap redirects, and handshakes each fetch with instruction memory.
- Sits between the decode/ALU control outputs and the instruction-memory address port.

Parameters:
- WIDTH, 32, PC and immediate width (word-addressed PC)
- RESET_PC, 0, PC value loaded on reset
- TRAP_PC, 32'h0000_0010, PC loaded on trap redirect

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- fetch_ready  in  1  imem accepts the address presented on pc this cycle
- fetch_valid  out  1  pc is a valid fetch address
- pc  out  WIDTH  current program counter
- pc_plus1  out  WIDTH  pc + 1, combinational
- branch  in  1  current instruction is a conditional branch
- zero  in  1  ALU zero flag; branch taken = branch & zero
- sign_imm  in  WIDTH  signed branch offset, in words
- jump  in  1  current instruction is a jump
- jump_target  in  WIDTH  absolute jump address
- halt  in  1  current instruction is a halt
- trap_req  in  1  level request; held by requester until trap_ack
- trap_ack  out  1  one-cycle pulse when the trap redirect is taken
- state  out  2  00 BOOT, 01 RUN, 10 STALL, 11 HALTED

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (reset=1 at a clk edge):
  - pc=RESET_PC, state=BOOT, fetch_valid=0, trap_ack=0, trap_pend=0.
  - Reset overrides every other input in every state, including mid-stall and HALTED.
- Combinational outputs:
  - pc_plus1 = pc + 1, modulo 2^WIDTH.
  - branch_target = sign_imm + pc_plus1, modulo 2^WIDTH, two's complement, no overflow flag.
- BOOT:
  - fetch_valid=0.
  - Next cycle: RUN, unconditionally.
- RUN:
  - fetch_valid=1.
  - Handshake = fetch_valid & fetch_ready.
  - On handshake, pc updates next edge by priority: trap (trap_req|trap_pend) -> TRAP_PC; else jump -> jump_target; else branch&zero -> branch_target; else pc_plus1.
  - Taking the trap pulses trap_ack=1 for exactly that cycle and clears trap_pend.
  - halt on handshake with no trap: pc holds, next state HALTED. Trap beats halt.
  - No handshake (fetch_ready=0): pc held, next state STALL.
- STALL:
  - fetch_valid=1, pc held.
  - trap_req seen here sets trap_pend (sticky until taken), so a request that drops early is not lost.
  - On fetch_ready=1, behaves as a RUN handshake cycle (same priority and update), then returns to RUN.
- HALTED:
  - fetch_valid=0, pc frozen, trap_req ignored, trap_ack=0.
  - Only reset exits.
- Latency: one cycle from handshake to new pc. No redirect penalty and no bubble.
- Decode inputs (branch, zero, jump, halt, sign_imm, jump_target) are sampled only on a handshake cycle and ignored otherwise.
- Wrap-around: pc=2^WIDTH-1 with no redirect -> pc=0.

Optional Feature:
- PC_SEQ_PERF_EN defined: adds outputs retired_cnt and taken_cnt, 32 bits each.
  - retired_cnt increments on every handshake.
  - taken_cnt increments on each handshake with a jump, taken branch or trap.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Not defined: ports and counters are absent; behaviour otherwise identical.

Test Plan:
- Reset, then fetch_ready=1, no redirects, for 4 cycles -> state BOOT then RUN; pc sequence 0,1,2,3,4.
- pc=8, branch=1, zero=1, sign_imm=-3 (32'hFFFF_FFFD) on handshake -> next pc=6. Same with zero=0 -> next pc=9.
- pc=5, fetch_ready=0 for 3 cycles with jump=1, jump_target=40 -> pc stays 5 and state=STALL. When fetch_ready=1 -> next pc=40, state RUN.
- Stalled at pc=7: pulse trap_req for 1 cycle, then release fetch_ready with jump=1 -> trap_ack pulses, next pc=16 (TRAP_PC), jump ignored.
- halt=1 on handshake at pc=12 -> state HALTED, fetch_valid=0, pc=12 held for 10 cycles despite trap_req. Then reset=1 -> pc=0, state BOOT.
- pc=32'hFFFF_FFFF, no redirect, handshake -> pc=0. With PC_SEQ_PERF_EN: after the first test's 4 handshakes, retired_cnt=4 and taken_cnt=0.
